// File: rtl/rcu_rst_seq.sv
// Reset sequencer for the RCU domain resets: merges external and watchdog reset,
// holds all domains, optionally waits for PLL lock, then releases domains in ascending order.
module rcu_rst_seq #(
  parameter int RST_NUM      = 7,
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int STEP_CYCLES  = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               wdt_rst_n_i,
  input  logic               pll_en_i,
  input  logic               pll_lock_i,
  output logic [RST_NUM-1:0] rst_n_o,
  output logic               seq_done_o,
  output logic [1:0]         rst_cause_o,
  output logic               lock_tmo_o
);

  localparam int MAX_HS  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int MAX_ALL = (MAX_HS > LOCK_TIMEOUT) ? MAX_HS : LOCK_TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RST_NUM-1:0]     rst_n_q, rst_n_d;
  logic                   done_q, done_d;
  logic [1:0]             cause_q, cause_d;
  logic                   tmo_q, tmo_d;
  logic [SYNC_STAGES-1:0] wdt_sync_q, wdt_sync_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic                   wdt_synced;
  logic                   lock_synced;
  logic [RST_NUM-1:0]     rst_n_next;

  assign wdt_synced  = wdt_sync_q[SYNC_STAGES-1];
  assign lock_synced = lock_sync_q[SYNC_STAGES-1];
  assign rst_n_next  = (rst_n_q << 1) | RST_NUM'(1);

  always_comb begin
    wdt_sync_d  = {wdt_sync_q[SYNC_STAGES-2:0], wdt_rst_n_i};
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_lock_i};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    done_d  = (state_q == ST_DONE);
    cause_d = cause_q;
    tmo_d   = tmo_q;

    // A watchdog request overrides any step or lock expiry on the same edge.
    if (!wdt_synced) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
      cause_d = CAUSE_WDT;
      tmo_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (!pll_en_i || lock_synced) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d   = '0;
            rst_n_d = rst_n_next;
            if (rst_n_next[RST_NUM-1]) begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      rst_n_q     <= '0;
      done_q      <= 1'b0;
      cause_q     <= CAUSE_EXT;
      tmo_q       <= 1'b0;
      wdt_sync_q  <= '1;
      lock_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_n_q     <= rst_n_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
      tmo_q       <= tmo_d;
      wdt_sync_q  <= wdt_sync_d;
      lock_sync_q <= lock_sync_d;
    end
  end

  assign rst_n_o     = rst_n_q;
  assign seq_done_o  = done_q;
  assign rst_cause_o = cause_q;
  assign lock_tmo_o  = tmo_q;

endmodule
